mux_n_pipe: RTL
===============

Name: mux_n_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered valid/ready output stage.
- Successor to the fixed 4x32 combinational selector in the datapath; use it where a select path must be retimed (writeback/forwarding selects, bus muxing between stages).
- A two-entry skid buffer sustains one transfer per cycle under backpressure without a combinational ready path.

Parameters:
- WIDTH, 32, data width per input.
- N, 4, number of inputs, 2..16.
- SEL_W, $clog2(N), select width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*WIDTH  flattened inputs; input k at [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  binary select, sampled with in_data.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  WIDTH  selected data, registered.
- out_sel  out  SEL_W  select that produced out_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  sticky out-of-range select flag; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - in_ready=1, sel_err=0, state=EMPTY.
  - Both buffer entries are cleared.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready is a register output with no combinational path from out_ready.
- Selection: data = in_data[in_sel*WIDTH +: WIDTH] when in_sel < N; otherwise data = 0.
- Latency: 1 cycle. An accepted beat appears on out_data/out_sel in the next cycle.
- out_data/out_sel hold stable while out_valid=1 and out_ready=0.
- State machine (main register M, skid register S):
  - EMPTY (M, S empty):
    - accept -> load M, go ONE.
  - ONE (M full):
    - accept & transfer -> load M, stay ONE.
    - accept & no transfer -> load S, in_ready<=0, go TWO.
    - no accept & transfer -> go EMPTY.
    - else stay.
  - TWO (M, S full; in_ready=0):
    - transfer -> M<=S, in_ready<=1, go ONE.
    - else stay.
- out_valid = (state != EMPTY).
- Throughput: 1 beat/cycle while out_ready=1. Beats are delivered in order, none dropped or duplicated.
- in_valid while in_ready=0: ignored, no state change.
- Reset mid-operation: all buffered beats are discarded; the next cycle after release is EMPTY.
- N not a power of two: codes N..2^SEL_W-1 are out-of-range.

Optional Feature:
- Macro: MUXN_SEL_CHECK_EN.
- Defined:
  - An accepted beat with in_sel >= N sets sel_err (sticky until reset).
  - That beat still passes through, with zero data.
- Undefined:
  - sel_err is tied 0, no check logic.
  - Out-of-range selects still produce zero data.

Decomposition:
- Shared package mux_pkg holds:
  - enum mux_state_t {EMPTY, ONE, TWO}, 2-bit.
  - function to compute SEL_W from N.
- Sub-module mux_n_sel: purely combinational N:1 WIDTH-bit selector (zero on out-of-range), instanced once before the M/S registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, out_data=0, sel_err=0.
- Streaming, N=4, WIDTH=32:
  - Stimulus: inputs 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel 0,1,2,3 on consecutive cycles; out_ready=1.
  - Required: the same values appear one cycle later, one per cycle, with out_sel=0..3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while sending sel=1 then sel=2.
  - Required: in_ready drops after 2 accepts; out_data holds 0x22222222; on release, 0x22222222 then 0x33333333 with no loss.
- Out-of-range, N=3 with MUXN_SEL_CHECK_EN:
  - Stimulus: sel=3.
  - Required: out_data=0, sel_err=1 and it stays 1; without the macro, sel_err stays 0.
- Mid-operation reset: in state TWO, pulse rst_n low asynchronously between edges -> out_valid falls immediately; buffered beats are never emitted.
- Random: random in_valid/out_ready for 10k cycles, N=5, WIDTH=8 -> scoreboard order and values match; in_ready has no same-cycle dependence on out_ready.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared state encoding and select-width helper for mux_n_pipe.
// Revision: 1.0
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mux_state_t;

    // A two-input selector still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_n_sel.sv
`default_nettype none
// ============================================================================
// Module  : mux_n_sel
// Brief   : Combinational N:1 WIDTH-bit selector; out-of-range selects yield 0.
// Revision: 1.0
// ============================================================================
module mux_n_sel #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mux_n_pipe
// Brief   : N-input selector with a registered valid/ready skid-buffer stage.
//           Define MUXN_SEL_CHECK_EN to enable the sticky sel_err check.
// Revision: 1.0
// ============================================================================
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    mux_state_t        state_q;
    logic [WIDTH-1:0]  m_data_q;
    logic [SEL_W-1:0]  m_sel_q;
    logic [WIDTH-1:0]  s_data_q;
    logic [SEL_W-1:0]  s_sel_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [WIDTH-1:0]  beat_data_d;
    logic              accept;
    logic              xfer;

    mux_n_sel #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_sel (
        .data_i (in_data),
        .sel_i  (in_sel),
        .data_o (beat_data_d)
    );

    assign accept = in_valid & in_ready_q;
    assign xfer   = out_valid_q & out_ready;

    // in_ready only depends on registered state, never on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            m_data_q    <= '0;
            m_sel_q     <= '0;
            s_data_q    <= '0;
            s_sel_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        m_data_q    <= beat_data_d;
                        m_sel_q     <= in_sel;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        m_data_q <= beat_data_d;
                        m_sel_q  <= in_sel;
                    end else if (accept) begin
                        s_data_q   <= beat_data_d;
                        s_sel_q    <= in_sel;
                        in_ready_q <= 1'b0;
                        state_q    <= TWO;
                    end else if (xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        m_data_q   <= s_data_q;
                        m_sel_q    <= s_sel_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

`ifdef MUXN_SEL_CHECK_EN
    localparam logic [SEL_W:0] c_n_ext = (SEL_W+1)'(N);
    logic sel_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (accept && ({1'b0, in_sel} >= c_n_ext)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m_data_q;
    assign out_sel   = m_sel_q;

endmodule
`default_nettype wire
